i2c_master_ctrl: RTL and testbench

I2C_MASTER_CTRL -- requirements
Module: i2c_master_ctrl

---
 rtl/i2c_master_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_i2c_master_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_ctrl.sv
// I2C write-only master: START, 7-bit address + W, ACK, one data byte, ACK, STOP.
// Latency: done pulses 80*CLK_DIV cycles after start accept (44*CLK_DIV on address NACK).
// Backpressure: start is only sampled in IDLE; requests while busy are dropped.
module i2c_master_ctrl #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] slave_addr,
    input  logic [7:0] wr_data,
    output logic       busy,
    output logic       done,
    output logic       nack,
    output logic       scl,
    inout  logic       sda
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        STOP
    } state_t;

    localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);

    state_t     state;
    logic [7:0] div_cnt;
    logic [1:0] phase;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic [6:0] addr_q;
    logic [7:0] data_q;
    logic       ack_smp;
    logic       sda_low;

    state_t     nxt_state;
    logic [7:0] nxt_div;
    logic [1:0] nxt_phase;
    logic [2:0] nxt_bit;
    logic [7:0] nxt_shreg;
    logic       nxt_scl;
    logic       nxt_sda_low;
    logic       phase_end;
    logic       period_end;

    assign sda = sda_low ? 1'b0 : 1'bz;

    assign phase_end  = (div_cnt == DIV_MAX);
    assign period_end = phase_end && (phase == 2'd3);

    always_comb begin
        nxt_state = state;
        nxt_div   = div_cnt;
        nxt_phase = phase;
        nxt_bit   = bit_cnt;
        nxt_shreg = shreg;

        if (state == IDLE) begin
            if (start) begin
                nxt_state = START;
                nxt_div   = 8'd0;
                nxt_phase = 2'd0;
            end
        end else begin
            if (phase_end) begin
                nxt_div   = 8'd0;
                nxt_phase = phase + 2'd1;
            end else begin
                nxt_div = div_cnt + 8'd1;
            end

            if (period_end) begin
                nxt_div   = 8'd0;
                nxt_phase = 2'd0;
                case (state)
                    START: begin
                        nxt_state = ADDR;
                        nxt_shreg = {addr_q, 1'b0};
                        nxt_bit   = 3'd0;
                    end
                    ADDR: begin
                        if (bit_cnt == 3'd7) begin
                            nxt_state = ADDR_ACK;
                        end else begin
                            nxt_bit   = bit_cnt + 3'd1;
                            nxt_shreg = {shreg[6:0], 1'b0};
                        end
                    end
                    ADDR_ACK: begin
                        // A released (high) line at the sample point means no slave answered.
                        if (ack_smp) begin
                            nxt_state = STOP;
                        end else begin
                            nxt_state = DATA;
                            nxt_shreg = data_q;
                            nxt_bit   = 3'd0;
                        end
                    end
                    DATA: begin
                        if (bit_cnt == 3'd7) begin
                            nxt_state = DATA_ACK;
                        end else begin
                            nxt_bit   = bit_cnt + 3'd1;
                            nxt_shreg = {shreg[6:0], 1'b0};
                        end
                    end
                    DATA_ACK: nxt_state = STOP;
                    STOP:     nxt_state = IDLE;
                    default:  nxt_state = IDLE;
                endcase
            end
        end
    end

    // Line levels are decoded from the upcoming state so they stay aligned with the counters.
    always_comb begin
        nxt_scl     = 1'b1;
        nxt_sda_low = 1'b0;
        case (nxt_state)
            IDLE: begin
                nxt_scl     = 1'b1;
                nxt_sda_low = 1'b0;
            end
            START: begin
                nxt_scl     = (nxt_phase != 2'd3);
                nxt_sda_low = (nxt_phase != 2'd0);
            end
            STOP: begin
                nxt_scl     = (nxt_phase != 2'd0);
                nxt_sda_low = (nxt_phase != 2'd3);
            end
            ADDR, DATA: begin
                nxt_scl     = nxt_phase[1];
                nxt_sda_low = ~nxt_shreg[7];
            end
            default: begin
                nxt_scl     = nxt_phase[1];
                nxt_sda_low = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            div_cnt <= 8'd0;
            phase   <= 2'd0;
            bit_cnt <= 3'd0;
            shreg   <= 8'd0;
            addr_q  <= 7'd0;
            data_q  <= 8'd0;
            ack_smp <= 1'b0;
            sda_low <= 1'b0;
            scl     <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            nack    <= 1'b0;
        end else begin
            state   <= nxt_state;
            div_cnt <= nxt_div;
            phase   <= nxt_phase;
            bit_cnt <= nxt_bit;
            shreg   <= nxt_shreg;
            scl     <= nxt_scl;
            sda_low <= nxt_sda_low;
            busy    <= (nxt_state != IDLE);
            done    <= (state == STOP) && period_end;

            if (state == IDLE && start) begin
                addr_q <= slave_addr;
                data_q <= wr_data;
                nack   <= 1'b0;
            end

            if ((state == ADDR_ACK || state == DATA_ACK) && phase == 2'd2 && phase_end) begin
                ack_smp <= sda;
            end

            if ((state == ADDR_ACK || state == DATA_ACK) && period_end && ack_smp) begin
                nack <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: table of transactions plus random ones, bus compared cycle by
// cycle against a period/phase model of the I2C write sequence, plus abort and chaining cases.
module tb_i2c_master_ctrl;

    localparam int D   = 4;
    localparam int PER = 4 * D;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [6:0] slave_addr = 7'd0;
    logic [7:0] wr_data = 8'd0;
    logic       busy, done, nack, scl;
    logic       slave_low = 1'b0;
    wire        sda;

    assign sda = slave_low ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    i2c_master_ctrl #(.CLK_DIV(D)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .slave_addr (slave_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .nack       (nack),
        .scl        (scl),
        .sda        (sda)
    );

    typedef struct {
        logic [6:0] addr;
        logic [7:0] data;
        logic       aack;
        logic       dack;
        int         done_at;
        logic       exp_nack;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [6:0] a, input logic [7:0] d, input logic aa,
                                input logic da, input int dn, input logic nk);
        vec_t v;
        v.addr = a; v.data = d; v.aack = aa; v.dack = da; v.done_at = dn; v.exp_nack = nk;
        return v;
    endfunction

    // Expected {scl, sda_released, busy, done} at cycle t after the accept edge.
    function automatic logic [3:0] model_bus(input vec_t v, input int t);
        int         nper, p, ph;
        logic [7:0] abyte;
        logic       scl_e, rel_e;
        nper  = v.aack ? 20 : 11;
        abyte = {v.addr, 1'b0};
        if (t > nper * PER) return 4'b1100;
        if (t == nper * PER) return 4'b1101;
        p  = t / PER;
        ph = (t % PER) / D;
        if (p == 0) begin
            scl_e = (ph != 3);
            rel_e = (ph == 0);
        end else if (p == nper - 1) begin
            scl_e = (ph != 0);
            rel_e = (ph == 3);
        end else begin
            scl_e = (ph >= 2);
            if (p <= 8) rel_e = abyte[3'(8 - p)];
            else if (p >= 10 && p <= 17) rel_e = v.data[3'(17 - p)];
            else rel_e = 1'b1;
        end
        return {scl_e, rel_e, 1'b1, 1'b0};
    endfunction

    function automatic logic slave_want(input vec_t v, input int t);
        int p;
        p = t / PER;
        return (p == 9 && v.aack) || (p == 18 && v.aack && v.dack);
    endfunction

    task automatic run_txn(input vec_t v, input bit pre_started, input bit pulse40,
                           input bit chain, input vec_t nxt, input int abort_at);
        logic [3:0] exp_w;
        int         last;
        last = v.done_at;
        if (!pre_started) begin
            @(negedge clk);
            start      = 1'b1;
            slave_addr = v.addr;
            wr_data    = v.data;
        end
        for (int t = 0; t <= last + 1; t++) begin
            @(negedge clk);
            exp_w    = model_bus(v, t);
            exp_w[2] = exp_w[2] & ~slave_want(v, t);
            check($sformatf("bus a=%h d=%h t=%0d", v.addr, v.data, t), {scl, sda, busy, done}, exp_w);
            if (t == 0) check("nack_cleared", {3'b0, nack}, 4'b0000);
            if (t == last) begin
                check($sformatf("done_at_%0d", last), {3'b0, done}, 4'b0001);
                check("nack_at_done", {3'b0, nack}, {3'b0, v.exp_nack});
                if (chain) return;
            end
            if (t == abort_at) begin
                reset     = 1'b1;
                start     = 1'b0;
                slave_low = 1'b0;
                return;
            end
            start = (pulse40 && t == 39) || (chain && t >= last - 3);
            if (chain && t >= last - 3) begin
                slave_addr = nxt.addr;
                wr_data    = nxt.data;
            end else begin
                slave_addr = 7'($urandom);
                wr_data    = 8'($urandom);
            end
            slave_low = slave_want(v, t + 1);
        end
    endtask

    vec_t tbl[8];
    vec_t va, vb, vc;
    logic aa, da;
    bit   seen_done;

    initial begin
        tbl[0] = mk(7'h50, 8'hA5, 1'b1, 1'b1, 320, 1'b0);
        tbl[1] = mk(7'h3C, 8'h00, 1'b0, 1'b0, 176, 1'b1);
        tbl[2] = mk(7'h2A, 8'hFF, 1'b1, 1'b0, 320, 1'b1);
        for (int i = 3; i < 8; i++) begin
            aa = 1'($urandom);
            da = 1'($urandom);
            tbl[i] = mk(7'($urandom), 8'($urandom), aa, da, aa ? 80 * D : 44 * D, !(aa && da));
        end

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_bus", {scl, sda, busy, done}, 4'b1100);
        check("reset_nack", {3'b0, nack}, 4'b0000);

        // Reset wins over a simultaneous start.
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        check("reset_over_start", {scl, sda, busy, done}, 4'b1100);
        reset = 1'b0;
        start = 1'b0;

        for (int i = 0; i < 8; i++) run_txn(tbl[i], 1'b0, 1'b0, 1'b0, tbl[i], -1);

        // Ignored mid-transaction start, then start held through done.
        va = mk(7'h11, 8'h22, 1'b0, 1'b0, 176, 1'b1);
        vb = mk(7'h50, 8'h3C, 1'b1, 1'b1, 320, 1'b0);
        run_txn(va, 1'b0, 1'b1, 1'b1, vb, -1);
        run_txn(vb, 1'b1, 1'b0, 1'b0, vb, -1);

        // Reset in the middle of data bit 3.
        vc = mk(7'h50, 8'hA5, 1'b1, 1'b1, 320, 1'b0);
        run_txn(vc, 1'b0, 1'b0, 1'b0, vc, 13 * PER + 2 * D + 1);
        @(negedge clk);
        check("abort_bus", {scl, sda, busy, done}, 4'b1100);
        check("abort_nack", {3'b0, nack}, 4'b0000);
        reset     = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 2 * PER; i++) begin
            @(negedge clk);
            if (done || busy) seen_done = 1'b1;
        end
        check("abort_quiet", {3'b0, seen_done}, 4'b0000);
        run_txn(vc, 1'b0, 1'b0, 1'b0, vc, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
